// File: rtl/kuz_pkg.sv
// Kuznyechik shared definitions: pi S-box, L-transform coefficients,
// GF(2^8) multiply, linear transform L, round constants C[1..32] and the
// key-schedule FSM state type.
package kuz_pkg;

  localparam int NUM_RK   = 10;
  localparam int NUM_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Coefficient j multiplies byte a(15-j), i.e. index 0 applies to the MS byte.
  localparam logic [7:0] L_COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1 (low byte 0xC3).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'hC3) : (aa << 1);
    end
    return p;
  endfunction

  // L = R^16. Each R computes the weighted byte sum, shifts the block one
  // byte towards the LSB and inserts the sum at the MS byte.
  function automatic logic [127:0] l_lin(input logic [127:0] x);
    logic [127:0] s;
    logic [7:0]   acc;
    s = x;
    for (int r = 0; r < 16; r++) begin
      acc = '0;
      for (int j = 0; j < 16; j++) acc = acc ^ gf_mul(s[127-8*j -: 8], L_COEF[j]);
      s = {acc, s[127:8]};
    end
    return s;
  endfunction

  // C[i] = L(i) for i = 1..32, folded to constants at elaboration.
  function automatic logic [NUM_ITER*128-1:0] build_c_tab();
    logic [NUM_ITER*128-1:0] t;
    t = '0;
    for (int i = 1; i <= NUM_ITER; i++) t[(i-1)*128 +: 128] = l_lin(128'(i));
    return t;
  endfunction

  localparam logic [NUM_ITER*128-1:0] C_TAB = build_c_tab();

  // Zero-based lookup: c_const(n) returns C[n+1].
  function automatic logic [127:0] c_const(input logic [4:0] n);
    return C_TAB[32'(n)*128 +: 128];
  endfunction

endpackage

// File: rtl/kuz_lsx.sv
// Kuznyechik combinational round core: lsx_o = L(S(x_i ^ c_i)).
// Ports:
//   x_i   [127:0]  data block
//   c_i   [127:0]  round constant / round key
//   lsx_o [127:0]  transformed block
module kuz_lsx
  import kuz_pkg::*;
(
  input  logic [127:0] x_i,
  input  logic [127:0] c_i,
  output logic [127:0] lsx_o
);

  logic [127:0] xk;
  logic [127:0] s_out;

  always_comb begin
    xk    = x_i ^ c_i;
    s_out = '0;
    for (int b = 0; b < 16; b++) s_out[8*b +: 8] = SBOX[xk[8*b +: 8]];
  end

  assign lsx_o = l_lin(s_out);

endmodule

// File: rtl/key_schedule.sv
// Kuznyechik round-key expander. Loads the 256-bit master key on start_i,
// runs 32 Feistel iterations (one per clock) and fills a ten-entry key file
// that the key-XOR stage reads combinationally.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   start_i       one-cycle pulse, accepted in IDLE or DONE
//   key_i [255:0] master key, [255:128] = K1, [127:0] = K2
//   busy_o        expansion running
//   keys_valid_o  K1..K10 complete and stable
//   rk_idx_i[3:0] key select 0..9 -> K1..K10, 10..15 read as zero
//   rk_o [127:0]  selected round key, no register on the read path
//
// state     | meaning
// ST_IDLE   | out of reset, key file cleared
// ST_EXPAND | Feistel iterations in progress, start_i ignored
// ST_DONE   | all round keys valid; start_i reloads
module key_schedule
  import kuz_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         keys_valid_o,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_o
);

  state_e       state_q, state_d;
  logic [4:0]   iter_q, iter_d;
  logic [127:0] a1_q, a1_d;
  logic [127:0] a0_q, a0_d;
  logic [127:0] rk_q [NUM_RK];
  logic [127:0] rk_d [NUM_RK];

  logic [127:0] lsx_out;
  logic [127:0] a1_next;
  logic [3:0]   wr_idx;
  logic         load;

  kuz_lsx u_lsx (
    .x_i   (a1_q),
    .c_i   (c_const(iter_q)),
    .lsx_o (lsx_out)
  );

  assign a1_next = lsx_out ^ a0_q;
  assign load    = start_i && (state_q != ST_EXPAND);
  // Iteration iter_q+1 = 8g lands in rk[2g], rk[2g+1]; g-1 is iter_q[4:3].
  assign wr_idx  = 4'({iter_q[4:3], 1'b0}) + 4'd2;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    rk_d    = rk_q;
    if (load) begin
      state_d = ST_EXPAND;
      iter_d  = '0;
      a1_d    = key_i[255:128];
      a0_d    = key_i[127:0];
      rk_d[0] = key_i[255:128];
      rk_d[1] = key_i[127:0];
    end else if (state_q == ST_EXPAND) begin
      a1_d   = a1_next;
      a0_d   = a1_q;
      iter_d = iter_q + 5'd1;
      if (iter_q[2:0] == 3'd7) begin
        rk_d[wr_idx]        = a1_next;
        rk_d[wr_idx + 4'd1] = a1_q;
      end
      if (iter_q == 5'(NUM_ITER - 1)) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      a1_q    <= '0;
      a0_q    <= '0;
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      rk_q    <= rk_d;
    end
  end

  assign busy_o       = (state_q == ST_EXPAND);
  assign keys_valid_o = (state_q == ST_DONE);
  assign rk_o         = (rk_idx_i < 4'(NUM_RK)) ? rk_q[rk_idx_i] : '0;

endmodule

// File: tb/tb_key_schedule.sv
module tb_key_schedule;
  import kuz_pkg::*;

  localparam logic [255:0] STD_KEY =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] ALT_KEY =
    256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_K3  = 128'hdb31485315694343228d6aef8cc78c44;
  localparam logic [127:0] STD_K4  = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
  localparam logic [127:0] STD_K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
  localparam logic [127:0] C1_LIT  = 128'h6ea276726c487ab85d27bd10dd849401;
  localparam logic [7:0] TB_COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [255:0] key_i;
  logic         busy_o;
  logic         keys_valid_o;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_o;
  logic [127:0] lsx_x, lsx_c, lsx_y;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_k [10];
  logic [127:0] std_k [10];

  key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .keys_valid_o (keys_valid_o),
    .rk_idx_i     (rk_idx_i),
    .rk_o         (rk_o)
  );

  kuz_lsx u_lsx (
    .x_i   (lsx_x),
    .c_i   (lsx_c),
    .lsx_o (lsx_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h01C3 << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] m_l(input logic [127:0] x);
    logic [7:0]   b [16];
    logic [7:0]   t;
    logic [127:0] r;
    for (int j = 0; j < 16; j++) b[j] = x[127-8*j -: 8];
    for (int n = 0; n < 16; n++) begin
      t = '0;
      for (int j = 0; j < 16; j++) t = t ^ m_mul(b[j], TB_COEF[j]);
      for (int j = 15; j > 0; j--) b[j] = b[j-1];
      b[0] = t;
    end
    r = '0;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = b[j];
    return r;
  endfunction

  function automatic logic [127:0] m_lsx(input logic [127:0] x, input logic [127:0] c);
    logic [127:0] v;
    logic [127:0] s;
    v = x ^ c;
    s = '0;
    for (int j = 0; j < 16; j++) s[8*j +: 8] = kuz_pkg::SBOX[v[8*j +: 8]];
    return m_l(s);
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [127:0] a1, a0, t;
    a1 = key[255:128];
    a0 = key[127:0];
    exp_k[0] = a1;
    exp_k[1] = a0;
    for (int i = 1; i <= 32; i++) begin
      t  = m_lsx(a1, m_l(128'(i))) ^ a0;
      a0 = a1;
      a1 = t;
      if (i % 8 == 0) begin
        exp_k[2*(i/8)]     = a1;
        exp_k[2*(i/8) + 1] = a0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; key_i = '0; rk_idx_i = '0;
    lsx_x = '0; lsx_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (keys_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", keys_valid_o); end
    for (int i = 0; i < 10; i++) begin
      rk_idx_i = 4'(i); #1;
      total++; if (rk_o !== 128'h0) begin bad++; $display("FAIL reset_rk%0d: got %h want 0", i, rk_o); end
    end
  endtask

  task automatic test_mid_reset();
    key_i = STD_KEY; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (13) tick();                      // iteration counter now 13
    rk_idx_i = 4'd2; #1;
    total++; if (rk_o !== std_k[2]) begin bad++; $display("FAIL midrst_pre_k3: got %h want %h", rk_o, std_k[2]); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy: got %b want 1", busy_o); end
    #1 rst = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    total++; if (keys_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", keys_valid_o); end
    for (int i = 0; i < 16; i++) begin
      rk_idx_i = 4'(i); #0.1;
      total++; if (rk_o !== 128'h0) begin bad++; $display("FAIL midrst_rk%0d: got %h want 0", i, rk_o); end
    end
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_standard();
    key_i = STD_KEY; start_i = 1'b1;
    tick();                                  // T0
    start_i = 1'b0; key_i = ALT_KEY;
    total++; if (busy_o !== 1'b1 || keys_valid_o !== 1'b0) begin bad++;
      $display("FAIL std_t0_flags: got busy=%b valid=%b want busy=1 valid=0", busy_o, keys_valid_o); end
    rk_idx_i = 4'd0; #1;
    total++; if (rk_o !== STD_KEY[255:128]) begin bad++; $display("FAIL std_t0_k1: got %h want %h", rk_o, STD_KEY[255:128]); end
    rk_idx_i = 4'd1; #1;
    total++; if (rk_o !== STD_KEY[127:0]) begin bad++; $display("FAIL std_t0_k2: got %h want %h", rk_o, STD_KEY[127:0]); end
    rk_idx_i = 4'd2;
    repeat (7) tick();                       // T0+7
    total++; if (rk_o !== 128'h0) begin bad++; $display("FAIL std_k3_early: got %h want 0", rk_o); end
    tick();                                  // T0+8
    total++; if (rk_o !== STD_K3) begin bad++; $display("FAIL std_k3_t8: got %h want %h", rk_o, STD_K3); end
    repeat (23) tick();                      // T0+31
    total++; if (busy_o !== 1'b1 || keys_valid_o !== 1'b0) begin bad++;
      $display("FAIL std_t31_flags: got busy=%b valid=%b want busy=1 valid=0", busy_o, keys_valid_o); end
    tick();                                  // T0+32
    total++; if (busy_o !== 1'b0 || keys_valid_o !== 1'b1) begin bad++;
      $display("FAIL std_t32_flags: got busy=%b valid=%b want busy=0 valid=1", busy_o, keys_valid_o); end
    rk_idx_i = 4'd2; #1;
    total++; if (rk_o !== STD_K3) begin bad++; $display("FAIL std_k3: got %h want %h", rk_o, STD_K3); end
    rk_idx_i = 4'd3; #1;
    total++; if (rk_o !== STD_K4) begin bad++; $display("FAIL std_k4: got %h want %h", rk_o, STD_K4); end
    rk_idx_i = 4'd9; #1;
    total++; if (rk_o !== STD_K10) begin bad++; $display("FAIL std_k10: got %h want %h", rk_o, STD_K10); end
    for (int i = 0; i < 10; i++) begin
      rk_idx_i = 4'(i); #1;
      total++; if (rk_o !== std_k[i]) begin bad++; $display("FAIL std_model_k%0d: got %h want %h", i + 1, rk_o, std_k[i]); end
    end
  endtask

  task automatic test_lsx();
    lsx_x = '0; lsx_c = C1_LIT; #1;
    total++; if (lsx_y !== m_lsx(128'h0, C1_LIT)) begin bad++;
      $display("FAIL lsx_c1: got %h want %h", lsx_y, m_lsx(128'h0, C1_LIT)); end
    lsx_x = C1_LIT; lsx_c = kuz_pkg::c_const(5'd0); #1;
    total++; if (lsx_y !== m_lsx(128'h0, 128'h0)) begin bad++;
      $display("FAIL lsx_ctab1: got %h want %h", lsx_y, m_lsx(128'h0, 128'h0)); end
    lsx_x = 128'h0123456789abcdeffedcba9876543210; lsx_c = 128'h00112233445566778899aabbccddeeff; #1;
    total++; if (lsx_y !== m_lsx(lsx_x, lsx_c)) begin bad++;
      $display("FAIL lsx_mixed: got %h want %h", lsx_y, m_lsx(lsx_x, lsx_c)); end
  endtask

  task automatic test_ignore_start();
    key_i = STD_KEY; start_i = 1'b1;
    tick();                                  // T0
    start_i = 1'b0;
    total++; if (keys_valid_o !== 1'b0) begin bad++; $display("FAIL ign_valid_t0: got %b want 0", keys_valid_o); end
    repeat (9) tick();
    key_i = ALT_KEY; start_i = 1'b1;
    tick();                                  // T0+10, start during EXPAND
    start_i = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL ign_busy_t10: got %b want 1", busy_o); end
    repeat (21) tick();                      // T0+31
    total++; if (keys_valid_o !== 1'b0) begin bad++; $display("FAIL ign_valid_t31: got %b want 0", keys_valid_o); end
    tick();                                  // T0+32
    total++; if (keys_valid_o !== 1'b1) begin bad++; $display("FAIL ign_valid_t32: got %b want 1", keys_valid_o); end
    for (int i = 0; i < 10; i++) begin
      rk_idx_i = 4'(i); #1;
      total++; if (rk_o !== std_k[i]) begin bad++; $display("FAIL ign_k%0d: got %h want %h", i + 1, rk_o, std_k[i]); end
    end
    rk_idx_i = 4'd9; #1;
    total++; if (rk_o !== STD_K10) begin bad++; $display("FAIL ign_k10_lit: got %h want %h", rk_o, STD_K10); end
  endtask

  task automatic test_restart_zero();
    model_expand(256'h0);
    key_i = '0; start_i = 1'b1;
    tick();                                  // T0
    start_i = 1'b0; key_i = STD_KEY;
    total++; if (keys_valid_o !== 1'b0 || busy_o !== 1'b1) begin bad++;
      $display("FAIL rz_t0_flags: got busy=%b valid=%b want busy=1 valid=0", busy_o, keys_valid_o); end
    repeat (31) tick();                      // T0+31
    total++; if (keys_valid_o !== 1'b0) begin bad++; $display("FAIL rz_valid_t31: got %b want 0", keys_valid_o); end
    tick();                                  // T0+32
    total++; if (keys_valid_o !== 1'b1 || busy_o !== 1'b0) begin bad++;
      $display("FAIL rz_t32_flags: got busy=%b valid=%b want busy=0 valid=1", busy_o, keys_valid_o); end
    for (int i = 0; i < 10; i++) begin
      rk_idx_i = 4'(i); #1;
      total++; if (rk_o !== exp_k[i]) begin bad++; $display("FAIL rz_k%0d: got %h want %h", i + 1, rk_o, exp_k[i]); end
    end
  endtask

  task automatic test_idx_range();
    for (int i = 10; i < 16; i++) begin
      rk_idx_i = 4'(i); #1;
      total++; if (rk_o !== 128'h0) begin bad++; $display("FAIL oob_idx%0d: got %h want 0", i, rk_o); end
    end
    rk_idx_i = 4'd12;
    repeat (3) tick();
    total++; if (busy_o !== 1'b0 || rk_o !== 128'h0) begin bad++;
      $display("FAIL oob_hold: got busy=%b rk=%h want busy=0 rk=0", busy_o, rk_o); end
  endtask

  initial begin
    model_expand(STD_KEY);
    for (int i = 0; i < 10; i++) std_k[i] = exp_k[i];
    test_reset();
    test_mid_reset();
    test_standard();
    test_lsx();
    test_ignore_start();
    test_restart_zero();
    test_idx_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
